conv_window_scheduler: RTL and testbench

//   Sequences one convolution dot product over the IF scratchpad and the filter SRAM.
//   - Waits until the circular IF scratchpad holds a full window.
//   - Issues FILTER_SIZE paired reads: IF entry and filter tap.
//   - Accumulates the signed products and hands the partial sum downstream over a valid/ready handshake.
//   - Sits between the IF write-side producer, the two 1-cycle-latency SRAM read ports and the psum consumer.

---
 rtl/conv_window_scheduler.sv | 150 +++++++++++++++
 tb/tb_conv_window_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_scheduler.sv
// Sequences one convolution window: waits for FILTER_SIZE IF entries, issues paired
// IF/filter reads, accumulates signed products and hands the psum over valid/ready.
module conv_window_scheduler #(
  parameter int ADDR_LEN        = 4,
  parameter int SCRATCH_DEPTH   = 16,
  parameter int FILT_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH      = 16,
  parameter int PSUM_WIDTH      = 32,
  parameter int FILTER_SIZE     = 4,
  parameter int STRIDE          = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ADDR_LEN-1:0]        if_start_ptr,
  input  logic [ADDR_LEN-1:0]        if_end_ptr,
  input  logic [FILT_ADDR_WIDTH-1:0] filt_base,
  output logic [ADDR_LEN-1:0]        if_rd_addr,
  input  logic [DATA_WIDTH-1:0]      if_rd_data,
  output logic [FILT_ADDR_WIDTH-1:0] filt_rd_addr,
  input  logic [DATA_WIDTH-1:0]      filt_rd_data,
  output logic [PSUM_WIDTH-1:0]      psum_data,
  output logic                       psum_valid,
  input  logic                       psum_ready,
  output logic                       if_advance,
  output logic                       busy,
  output logic                       done
);

  localparam int AW1 = ADDR_LEN + 1;
  localparam logic [AW1-1:0]      DEPTH_C  = AW1'(SCRATCH_DEPTH);
  localparam logic [AW1-1:0]      FSIZE_C  = AW1'(FILTER_SIZE);
  localparam logic [ADDR_LEN-1:0] LAST_TAP = ADDR_LEN'(FILTER_SIZE - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  if ((SCRATCH_DEPTH > (1 << ADDR_LEN)) || (FILTER_SIZE < 1) ||
      (FILTER_SIZE > SCRATCH_DEPTH - 1) || (STRIDE < 1) || (STRIDE > FILTER_SIZE) ||
      (PSUM_WIDTH < 2 * DATA_WIDTH)) begin : g_bad_params
    $error("conv_window_scheduler: illegal parameter combination");
  end

  logic [2:0]                  state_q, state_d;
  logic [ADDR_LEN-1:0]         sp_q, sp_d;
  logic [ADDR_LEN-1:0]         tap_q, tap_d;
  logic [FILT_ADDR_WIDTH-1:0]  fb_q, fb_d;
  logic signed [PSUM_WIDTH-1:0] acc_q, acc_d;
  logic                        mac_vld_p1_q, mac_vld_p1_d;
  logic [AW1-1:0]              avail;
  logic                        fetching;

  // Entries between read and write pointer; equal pointers mean empty.
  function automatic logic [AW1-1:0] occupancy(input logic [ADDR_LEN-1:0] rd,
                                               input logic [ADDR_LEN-1:0] wr);
    logic [AW1-1:0] r;
    logic [AW1-1:0] w;
    r = AW1'(rd);
    w = AW1'(wr);
    return (r > w) ? (DEPTH_C - (r - w)) : (w - r);
  endfunction

  function automatic logic [ADDR_LEN-1:0] wrap_add(input logic [ADDR_LEN-1:0] base,
                                                   input logic [ADDR_LEN-1:0] off);
    logic [AW1-1:0] s;
    s = AW1'(base) + AW1'(off);
    if (s >= DEPTH_C) s = s - DEPTH_C;
    return s[ADDR_LEN-1:0];
  endfunction

  // Full-precision signed product, sign-extended; accumulation wraps, never saturates.
  function automatic logic signed [PSUM_WIDTH-1:0] mac_term(input logic signed [DATA_WIDTH-1:0] a,
                                                            input logic signed [DATA_WIDTH-1:0] b);
    logic signed [2*DATA_WIDTH-1:0] p;
    p = a * b;
    return PSUM_WIDTH'(p);
  endfunction

  assign avail    = occupancy(sp_q, if_end_ptr);
  assign fetching = (state_q == S_FETCH);

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    fb_d    = fb_q;
    tap_d   = tap_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sp_d    = if_start_ptr;
          fb_d    = filt_base;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (avail >= FSIZE_C) begin
          tap_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (tap_q == LAST_TAP) state_d = S_DRAIN;
        else                   tap_d   = tap_q + ADDR_LEN'(1);
      end
      S_DRAIN: state_d = S_OUT;
      S_OUT: begin
        if (psum_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage p1: read data of the tap issued last cycle is folded into the accumulator.
  always_comb begin
    mac_vld_p1_d = fetching;
    acc_d        = acc_q;
    if ((state_q == S_IDLE) && start) acc_d = '0;
    else if (mac_vld_p1_q) acc_d = acc_q + mac_term($signed(if_rd_data), $signed(filt_rd_data));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sp_q         <= '0;
      fb_q         <= '0;
      tap_q        <= '0;
      acc_q        <= '0;
      mac_vld_p1_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sp_q         <= sp_d;
      fb_q         <= fb_d;
      tap_q        <= tap_d;
      acc_q        <= acc_d;
      mac_vld_p1_q <= mac_vld_p1_d;
    end
  end

  assign if_rd_addr   = fetching ? wrap_add(sp_q, tap_q) : '0;
  assign filt_rd_addr = fetching ? (fb_q + FILT_ADDR_WIDTH'(tap_q)) : '0;
  assign psum_valid   = (state_q == S_OUT);
  assign psum_data    = psum_valid ? acc_q : '0;
  assign done         = psum_valid && psum_ready;
  assign if_advance   = psum_valid && psum_ready;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed and randomized windows against a dot-product reference over bench-owned SRAMs.
module tb_conv_window_scheduler;
  localparam int FS = 4;
  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  if_start_ptr;
  logic [3:0]  if_end_ptr;
  logic [7:0]  filt_base;
  logic [3:0]  if_rd_addr;
  logic [15:0] if_rd_data;
  logic [7:0]  filt_rd_addr;
  logic [15:0] filt_rd_data;
  logic [31:0] psum_data;
  logic        psum_valid;
  logic        psum_ready;
  logic        if_advance;
  logic        busy;
  logic        done;

  logic [15:0] if_mem [DEPTH];
  logic [15:0] filt_mem [256];

  int n_chk = 0;
  int n_pass = 0;

  conv_window_scheduler #(
    .ADDR_LEN(4), .SCRATCH_DEPTH(DEPTH), .FILT_ADDR_WIDTH(8), .DATA_WIDTH(16),
    .PSUM_WIDTH(32), .FILTER_SIZE(FS), .STRIDE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .if_start_ptr(if_start_ptr),
    .if_end_ptr(if_end_ptr), .filt_base(filt_base), .if_rd_addr(if_rd_addr),
    .if_rd_data(if_rd_data), .filt_rd_addr(filt_rd_addr), .filt_rd_data(filt_rd_data),
    .psum_data(psum_data), .psum_valid(psum_valid), .psum_ready(psum_ready),
    .if_advance(if_advance), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // 1-cycle-latency SRAM read ports
  always @(posedge clk) begin
    if_rd_data   <= if_mem[if_rd_addr];
    filt_rd_data <= filt_mem[filt_rd_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int avail_of(input int sp, input int ep);
    return (ep - sp + DEPTH) % DEPTH;
  endfunction

  function automatic logic [31:0] model_sum(input int sp, input int fb);
    longint s;
    s = 0;
    for (int i = 0; i < FS; i++)
      s += longint'($signed(if_mem[(sp + i) % DEPTH])) * longint'($signed(filt_mem[fb + i]));
    return s[31:0];
  endfunction

  task automatic randomize_mems();
    for (int i = 0; i < DEPTH; i++) if_mem[i] = 16'($urandom);
    for (int i = 0; i < 256; i++) filt_mem[i] = 16'($urandom);
  endtask

  // One window: write pointer ep0 until cycle ep_chg, then ep1; consumer stalls 'hold' cycles.
  task automatic run_window(input int sp, input int ep0, input int ep1, input int ep_chg,
                            input int fb, input int hold, output logic [31:0] got);
    int fetch0;
    logic [31:0] exp_sum;
    exp_sum = model_sum(sp, fb);
    fetch0 = 0;
    got = '0;
    for (int k = 1; k < 64; k++)
      if (fetch0 == 0 && avail_of(sp, (k >= ep_chg) ? ep1 : ep0) >= FS) fetch0 = k + 1;
    @(negedge clk);
    start = 1'b1;
    if_start_ptr = 4'(sp);
    filt_base = 8'(fb);
    if_end_ptr = 4'(ep0);
    psum_ready = 1'b0;
    #1 chk("idle_before_start", busy, 0);
    for (int c = 1; c <= fetch0 + FS; c++) begin
      @(negedge clk);
      start = 1'($urandom);
      if_start_ptr = 4'($urandom);
      filt_base = 8'($urandom);
      if_end_ptr = 4'((c >= ep_chg) ? ep1 : ep0);
      psum_ready = (hold == 0) ? 1'b1 : 1'($urandom);
      #1;
      chk("busy_in_window", busy, 1);
      chk("no_early_out", {psum_valid, done, if_advance}, 0);
      if (c >= fetch0 && c < fetch0 + FS) begin
        chk("if_rd_addr", if_rd_addr, (sp + c - fetch0) % DEPTH);
        chk("filt_rd_addr", filt_rd_addr, fb + c - fetch0);
      end
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      psum_ready = (h == hold);
      start = (h == hold);
      #1;
      chk("psum_valid", psum_valid, 1);
      chk("psum_data", psum_data, exp_sum);
      chk("done_adv", {done, if_advance}, (h == hold) ? 2'b11 : 2'b00);
      got = psum_data;
    end
    @(negedge clk);
    start = 1'b0;
    psum_ready = 1'b0;
    #1 chk("idle_after", {busy, psum_valid, done, if_advance}, 0);
  endtask

  initial begin
    logic [31:0] got;
    int sp, ep0, ep1, chg;
    clk = 1'b0;
    rst_n = 1'b1;
    start = 1'b0;
    if_start_ptr = '0;
    if_end_ptr = '0;
    filt_base = '0;
    psum_ready = 1'b0;
    randomize_mems();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctrl", {busy, psum_valid, done, if_advance}, 0);
    chk("reset_addr", {if_rd_addr, filt_rd_addr}, 0);
    chk("reset_psum", psum_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic window: -3
    if_mem[0] = 16'd1; if_mem[1] = 16'd2; if_mem[2] = 16'd3; if_mem[3] = 16'd4;
    filt_mem[0] = 16'd1; filt_mem[1] = 16'hFFFF; filt_mem[2] = 16'd2; filt_mem[3] = 16'hFFFE;
    run_window(0, 4, 4, 1, 0, 0, got);
    chk("t1_sum", got, 32'hFFFF_FFFD);

    // Pointer wrap 14,15,0,1
    run_window(14, 2, 2, 1, 40, 1, got);

    // Stall until write pointer reaches 4 at cycle 10
    run_window(0, 2, 4, 10, 100, 0, got);

    // Consumer back-pressure for 5 cycles
    run_window(5, 12, 12, 1, 7, 5, got);

    // 4 * 2**30 wraps to zero
    for (int i = 0; i < FS; i++) begin
      if_mem[i] = 16'h8000;
      filt_mem[i] = 16'h8000;
    end
    run_window(0, 4, 4, 1, 0, 0, got);
    chk("t5_wrap_zero", got, 0);

    // Asynchronous reset in the middle of FETCH
    randomize_mems();
    @(negedge clk);
    start = 1'b1; if_start_ptr = 4'd0; if_end_ptr = 4'd4; filt_base = 8'd0; psum_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 chk("t6_fetching", busy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_ctrl", {busy, psum_valid, done, if_advance}, 0);
    chk("t6_async_addr", {if_rd_addr, filt_rd_addr}, 0);
    chk("t6_async_psum", psum_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    psum_ready = 1'b0;
    run_window(3, 9, 9, 1, 20, 2, got);

    // Randomized windows, some with an initial stall
    for (int n = 0; n < 10; n++) begin
      randomize_mems();
      sp = int'($urandom % DEPTH);
      ep1 = (sp + FS + int'($urandom % (DEPTH - FS))) % DEPTH;
      if ($urandom % 2 == 1) begin
        ep0 = (sp + int'($urandom % FS)) % DEPTH;
        chg = 1 + int'($urandom % 6);
      end else begin
        ep0 = ep1;
        chg = 1;
      end
      run_window(sp, ep0, ep1, chg, int'($urandom % 250), int'($urandom % 4), got);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
